read_channel_fsm: RTL

Read-side channel sequencer of the DMA and counterpart of the write channel FSM. It takes the active channel set from the CFG FSM and fetches each channel's burst configuration and source address from the register file. It splits the channel length into legal AXI4 read bursts (max 256 beats, FIXED max 16 beats, no 4KB crossing) and drives the master controller's read port one burst at a time.

---
 rtl/read_channel_fsm_if.sv | 48 ++++
 rtl/read_channel_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/read_channel_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : read_channel_fsm_if
// Brief    : Bundle of the read channel sequencer's handshake signals: the
//            channel set from the CFG FSM, the register file read port, the
//            master controller read port and the status pulses.
//            master = sequencer side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface read_channel_fsm_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int REGFILE_ADDR_WIDTH = 8,
  parameter int REGFILE_DATA_WIDTH = 32
);
  // Channel set from the CFG FSM
  logic                          validChannels;
  logic [31:0]                   activeChannels;
  // Register file read port
  logic                          regFile_readEnable;
  logic [REGFILE_ADDR_WIDTH-1:0] regFile_readAddr;
  logic [REGFILE_DATA_WIDTH-1:0] regFile_readData;
  // Master controller read port
  logic                          start_read;
  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr;
  logic [1:0]                    burst_type;
  logic [2:0]                    burst_size;
  logic [8:0]                    beats;
  logic                          read_transaction_completed;
  // Status
  logic                          channel_done;
  logic                          channel_error;
  logic [4:0]                    channel_id;
  logic                          all_done;
  logic                          busy;

  modport master (
    input  validChannels, activeChannels, regFile_readData, read_transaction_completed,
    output regFile_readEnable, regFile_readAddr, start_read, src_addr, burst_type,
           burst_size, beats, channel_done, channel_error, channel_id, all_done, busy
  );

  modport slave (
    output validChannels, activeChannels, regFile_readData, read_transaction_completed,
    input  regFile_readEnable, regFile_readAddr, start_read, src_addr, burst_type,
           burst_size, beats, channel_done, channel_error, channel_id, all_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/read_channel_fsm.sv
`default_nettype none
// ============================================================================
// Module   : read_channel_fsm
// Brief    : DMA read-side channel sequencer. Walks the pending channel set
//            lowest channel first, fetches each channel's config and source
//            address from the register file, and issues legal AXI4 read
//            bursts (<=256 beats, FIXED <=16 beats, no 4KB crossing).
// Revision : 1.0 - initial release
// ============================================================================
module read_channel_fsm #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int REGFILE_ADDR_WIDTH = 8,
  parameter int REGFILE_DATA_WIDTH = 32,
  parameter int NUM_CHANNELS       = 32
) (
  input  wire logic           AXI_aclk,
  input  wire logic           AXI_aresetn,
  read_channel_fsm_if.master  bus
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int RA = REGFILE_ADDR_WIDTH;
  localparam logic [1:0] C_FIXED = 2'b00;
  localparam logic [1:0] C_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_REQ, S_ADDR_REQ, S_ADDR_CAP, S_PLAN, S_ISSUE, S_WAIT_RESP, S_NEXT_CH
  } state_t;

  state_t                  state_q;
  logic [NUM_CHANNELS-1:0] pending_q;
  logic [4:0]              cur_ch_q;
  logic [1:0]              type_q;
  logic [2:0]              size_q;
  logic [15:0]             remaining_q;
  logic [AW-1:0]           cur_addr_q;

  logic                    rd_en_q;
  logic [RA-1:0]           rd_addr_q;
  logic                    start_q;
  logic [AW-1:0]           src_addr_q;
  logic [1:0]              btype_q;
  logic [2:0]              bsize_q;
  logic [8:0]              beats_q;
  logic                    done_q;
  logic                    err_q;
  logic [4:0]              id_q;
  logic                    all_done_q;

  logic [NUM_CHANNELS-1:0] pending_d;
  logic [4:0]              next_ch_d;
  logic [12:0]             room_d;
  logic [12:0]             cap_d;
  logic [8:0]              beats_d;
  logic [15:0]             rem_next_d;
  logic                    misalign_d;
  logic                    illegal_d;
  logic                    unused_bits;

  // Pending set: retire the served channel in NEXT_CH; a new strobe ORs in
  // afterwards so a re-request of the same channel wins over the clear.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_NEXT_CH) pending_d[cur_ch_q] = 1'b0;
    if (bus.validChannels) pending_d = pending_d | bus.activeChannels[NUM_CHANNELS-1:0];
  end

  // Lowest set bit of the upcoming pending set selects the next channel.
  always_comb begin
    next_ch_d = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (pending_d[i]) next_ch_d = 5'(i);
    end
  end

  // Burst planning and legality checks.
  always_comb begin
    room_d     = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> size_q;
    if (type_q == C_FIXED) cap_d = 13'd16;
    else                   cap_d = (room_d > 13'd256) ? 13'd256 : room_d;
    beats_d    = (remaining_q < {3'b000, cap_d}) ? remaining_q[8:0] : cap_d[8:0];
    rem_next_d = remaining_q - {7'd0, beats_q};
    misalign_d = ((size_q == 3'd1) && bus.regFile_readData[0]) ||
                 ((size_q == 3'd2) && (bus.regFile_readData[1:0] != 2'b00));
    illegal_d  = type_q[1] || (size_q > 3'd2) || ((type_q == C_INCR) && misalign_d);
  end

  // Config word bits that carry no meaning for the read side.
  assign unused_bits = ^{bus.regFile_readData[REGFILE_DATA_WIDTH-1:27],
                         bus.regFile_readData[21:16]};

  // Sequencer FSM with registered outputs; status pulses default low.
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      cur_ch_q    <= '0;
      type_q      <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      start_q     <= 1'b0;
      src_addr_q  <= '0;
      btype_q     <= '0;
      bsize_q     <= '0;
      beats_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      id_q        <= '0;
      all_done_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      all_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_d != '0) begin
            state_q   <= S_CFG_REQ;
            cur_ch_q  <= next_ch_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= RA'({next_ch_d, 2'b01});
          end
        end
        S_CFG_REQ: begin
          state_q   <= S_ADDR_REQ;
          rd_addr_q <= RA'({cur_ch_q, 2'b10});
        end
        S_ADDR_REQ: begin
          type_q      <= bus.regFile_readData[26:25];
          size_q      <= bus.regFile_readData[24:22];
          remaining_q <= bus.regFile_readData[15:0];
          rd_en_q     <= 1'b0;
          rd_addr_q   <= '0;
          state_q     <= S_ADDR_CAP;
        end
        S_ADDR_CAP: begin
          cur_addr_q <= bus.regFile_readData[AW-1:0];
          if (illegal_d) begin
            err_q   <= 1'b1;
            id_q    <= cur_ch_q;
            state_q <= S_NEXT_CH;
          end else if (remaining_q == 16'd0) begin
            done_q  <= 1'b1;
            id_q    <= cur_ch_q;
            state_q <= S_NEXT_CH;
          end else begin
            state_q <= S_PLAN;
          end
        end
        S_PLAN: begin
          beats_q    <= beats_d;
          src_addr_q <= cur_addr_q;
          btype_q    <= type_q;
          bsize_q    <= size_q;
          start_q    <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          state_q <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (bus.read_transaction_completed) begin
            remaining_q <= rem_next_d;
            if (type_q == C_INCR)
              cur_addr_q <= cur_addr_q + ({{(AW-9){1'b0}}, beats_q} << size_q);
            if (rem_next_d == 16'd0) begin
              done_q  <= 1'b1;
              id_q    <= cur_ch_q;
              state_q <= S_NEXT_CH;
            end else begin
              state_q <= S_PLAN;
            end
          end
        end
        S_NEXT_CH: begin
          if (pending_d == '0) begin
            all_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            state_q   <= S_CFG_REQ;
            cur_ch_q  <= next_ch_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= RA'({next_ch_d, 2'b01});
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.regFile_readEnable = rd_en_q;
  assign bus.regFile_readAddr   = rd_addr_q;
  assign bus.start_read         = start_q;
  assign bus.src_addr           = src_addr_q;
  assign bus.burst_type         = btype_q;
  assign bus.burst_size         = bsize_q;
  assign bus.beats              = beats_q;
  assign bus.channel_done       = done_q;
  assign bus.channel_error      = err_q;
  assign bus.channel_id         = id_q;
  assign bus.all_done           = all_done_q;
  assign bus.busy               = (state_q != S_IDLE);

endmodule
`default_nettype wire
